uart_autobaud: RTL and testbench
================================

// Module: uart_autobaud
// PURPOSE
//  Measures the bit period of incoming UART traffic on the rx line from a 0x55 ('U') sync character.
//  Sits on rx_i in parallel with, and upstream of, uart_hw.
//  Software reads cpb_o and programs it into uart_hw through CMDSETSPEED.
//  Frame 0x55 LSB-first = start0,1,0,1,0,1,0,1,0,stop1.
//  The 5 falling edges from start to b7 span exactly 8 bit periods.
// PARAMETERS
//  CPBBITSZ    30  width of cpb_o; matches CLOG2CLOCKCYCLESPERBITLIMIT for ARCHBITSZ=32
//  MINCPB      4   smallest accepted clock-cycles-per-bit; shorter span -> error
//  SYNCSTAGES  2   rx_i synchronizer flops (>=2)
//  FILTCYCLES  3   glitch-filter stability length; used only with UART_AUTOBAUD_GLITCHFILT_EN
// PORTS
//  rst_i    in   1         asynchronous active-high reset
//  clk_i    in   1         single clock; all logic on posedge
//  start_i  in   1         arm/re-arm a measurement (1-cycle pulse)
//  rx_i     in   1         raw asynchronous rx line, idle high
//  busy_o   out  1         measurement armed or in progress
//  valid_o  out  1         1-cycle pulse: cpb_o updated
//  err_o    out  1         1-cycle pulse: measurement rejected
//  cpb_o    out  CPBBITSZ  last good clock-cycles-per-bit
// BEHAVIOUR
//  - Reset values (async, immediate): busy_o=0, valid_o=0, err_o=0, cpb_o=0, state=IDLE, counters=0.
//    Synchronizer flops reset to 1 (idle line).
//  - rx_s = rx_i after SYNCSTAGES flops (optionally filtered); rx_q = rx_s delayed 1 cycle.
//    fall = rx_q & !rx_s. Both edges see the same pipeline delay, so the span is unbiased.
//  - span counter cnt: CPBBITSZ+3 bits. Edge counter fcnt: 3 bits.
//  - busy_o=1 in every state except IDLE.
//  - State IDLE: start_i -> ARM. Otherwise stay.
//  - State ARM: wait for rx_s==1 (line idle), then -> WAITSTART.
//  - State WAITSTART: on fall -> MEASURE, with cnt<=0 and fcnt<=0.
//  - State MEASURE, every cycle: cnt<=cnt+1. On fall: fcnt<=fcnt+1.
//  - MEASURE, fall while fcnt==3 (5th falling edge): span=cnt+1. Then -> IDLE.
//      - If span < 8*MINCPB: err_o=1 next cycle; cpb_o unchanged.
//      - Else: cpb_o<=(span+4)>>3 (round to nearest), truncated to CPBBITSZ; valid_o=1 next cycle.
//  - MEASURE, cnt all-ones (saturation, no 5th edge): err_o=1 next cycle; -> IDLE; cpb_o unchanged.
//  - start_i in any non-IDLE state restarts at ARM: counters cleared, no valid/err pulse.
//  - start_i wins over a same-cycle 5th edge: no pulse, restart.
//  - valid_o and err_o are never high together; each lasts exactly 1 cycle.
//  - cpb_o is stable between valid_o pulses.
//  - No 0x55 bit-pattern verification beyond edge count.
//    Any character with 5 falls in 8 bit times is accepted.
// CONFIGURATION
//  - UART_AUTOBAUD_GLITCHFILT_EN defined:
//      - Synchronized rx passes through a stability filter before rx_s.
//      - rx_s takes the new level only after the input has differed from rx_s for FILTCYCLES consecutive cycles.
//      - Pulses shorter than FILTCYCLES are ignored. Adds FILTCYCLES cycles of latency to both edges.
//  - UART_AUTOBAUD_GLITCHFILT_EN undefined:
//      - rx_s is the synchronizer output; every glitch is an edge.
//      - FILTCYCLES is unused; no filter logic is generated.
// TESTING (CPBBITSZ=8 for sim, so cnt saturates at 2047)
//  1. start_i, then 0x55 at 16 clk/bit -> valid_o 1 cycle, cpb_o=16, err_o never high, busy_o falls with valid_o.
//  2. 0x55 at 13 clk/bit -> span 104, cpb_o=13; then re-arm, 0x55 at 100 clk/bit -> cpb_o=100.
//  3. MINCPB=4, 0x55 at 2 clk/bit (span 16<32) -> err_o pulse, cpb_o keeps prior value 13.
//  4. start edge then line held low 3000 cycles -> err_o at cnt=2047, busy_o=0, valid_o never high.
//  5. 0x55 at 16 clk/bit with a 1-cycle low glitch inside b0:
//      - with _EN, FILTCYCLES=3 -> cpb_o=16;
//      - without _EN -> no valid_o with cpb_o=16 (err_o or a short cpb_o).
//  6. rst_i asserted mid-MEASURE -> outputs 0 immediately; after release, start_i plus 0x55 at 16 clk/bit -> cpb_o=16.
//     Separately, start_i mid-MEASURE -> no pulse, new measurement succeeds.

Source files
------------

// File: rtl/uart_autobaud.sv
// uart_autobaud
//   Measures the bit period of incoming UART traffic from a 0x55 ('U') sync
//   character. The five falling edges of 0x55 (start, b1, b3, b5, b7) span
//   exactly eight bit periods; the span is rounded to the nearest whole
//   clock-cycles-per-bit value and presented on cpb_o for software to program
//   into uart_hw.
//
//   Optional feature: define UART_AUTOBAUD_GLITCHFILT_EN to insert a stability
//   filter between the synchronizer and the edge detector. Pulses shorter than
//   FILTCYCLES clocks are then ignored. Without the macro, no filter logic is
//   built and FILTCYCLES has no effect.
module uart_autobaud #(
    parameter int CPBBITSZ   = 30,
    parameter int MINCPB     = 4,
    parameter int SYNCSTAGES = 2,
    parameter int FILTCYCLES = 3
) (
    input  logic                rst_i,
    input  logic                clk_i,
    input  logic                start_i,
    input  logic                rx_i,
    output logic                busy_o,
    output logic                valid_o,
    output logic                err_o,
    output logic [CPBBITSZ-1:0] cpb_o
);

    // Span counter is wide enough for 8 bit periods of the largest cpb_o.
    localparam int CNTW  = CPBBITSZ + 3;
    // One extra bit so that cnt+1 and the rounding add never wrap.
    localparam int SPANW = CPBBITSZ + 4;
    localparam logic [SPANW-1:0] MIN_SPAN = SPANW'(8 * MINCPB);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAITSTART,
        MEASURE
    } state_t;

    if (SYNCSTAGES < 2 || FILTCYCLES < 1) begin : g_bad_params
        $error("uart_autobaud: SYNCSTAGES must be >= 2 and FILTCYCLES >= 1");
    end

    logic [SYNCSTAGES-1:0] sync_q;
    logic                  rx_sync;
    logic                  rx_s;
    logic                  rx_q;
    logic                  fall;
    state_t                state;
    logic [CNTW-1:0]       cnt;
    logic [2:0]            fcnt;
    logic [SPANW-1:0]      span;
    logic [CPBBITSZ-1:0]   cpb_next;

    // Bring the asynchronous rx line into the clock domain.
    // NOTE: synchronizer flops reset to 1 so an idle line produces no false
    // falling edge when reset is released.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNCSTAGES-2:0], rx_i};
        end
    end

    assign rx_sync = sync_q[SYNCSTAGES-1];

`ifdef UART_AUTOBAUD_GLITCHFILT_EN
    localparam int FCW = $clog2(FILTCYCLES + 1);

    logic [FCW-1:0] filt_cnt;
    logic           rx_filt;

    // Accept a new level only after it has persisted for FILTCYCLES cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_filt  <= 1'b1;
            filt_cnt <= '0;
        end else if (rx_sync == rx_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FCW'(FILTCYCLES - 1)) begin
            rx_filt  <= rx_sync;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FCW'(1);
        end
    end

    assign rx_s = rx_filt;
`else
    assign rx_s = rx_sync;
`endif

    // One-cycle delayed copy of rx_s for falling-edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_q <= 1'b1;
        end else begin
            rx_q <= rx_s;
        end
    end

    // Both edges of the span see the same pipeline delay, so the span is exact.
    assign fall     = rx_q & ~rx_s;
    assign span     = {1'b0, cnt} + SPANW'(1);
    assign cpb_next = CPBBITSZ'((span + SPANW'(4)) >> 3);

    // Measurement FSM with registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            fcnt    <= '0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            cpb_o   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only; the
            // pulse defaults below are overridden later in the same block.
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            if (start_i) begin
                // Re-arm from any state; an in-flight measurement is dropped
                // silently, even if its fifth edge lands this same cycle.
                state  <= ARM;
                cnt    <= '0;
                fcnt   <= '0;
                busy_o <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy_o <= 1'b0;
                    end
                    ARM: begin
                        if (rx_s) begin
                            state <= WAITSTART;
                        end
                    end
                    WAITSTART: begin
                        if (fall) begin
                            state <= MEASURE;
                            cnt   <= '0;
                            fcnt  <= '0;
                        end
                    end
                    MEASURE: begin
                        if (fall && fcnt == 3'd3) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            if (span < MIN_SPAN) begin
                                err_o <= 1'b1;
                            end else begin
                                cpb_o   <= cpb_next;
                                valid_o <= 1'b1;
                            end
                        end else if (&cnt) begin
                            // No fifth edge within the counter range.
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            err_o  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNTW'(1);
                            if (fall) begin
                                fcnt <= fcnt + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud.sv
// tb_uart_autobaud
//   Scoreboard bench for uart_autobaud. Each measurement is described as a
//   per-clock waveform of the rx line; a reference model derives the expected
//   outcome from the falling edges of that waveform, and a monitor compares
//   every valid_o/err_o pulse against the queued expectation.
module tb_uart_autobaud;

    localparam int CPBBITSZ   = 8;
    localparam int MINCPB     = 4;
    localparam int SYNCSTAGES = 2;
    localparam int FILTCYCLES = 3;
    localparam int SAT        = (1 << (CPBBITSZ + 3)) - 1;
`ifdef UART_AUTOBAUD_GLITCHFILT_EN
    localparam int PMIN       = 4;
    localparam int P_SHORT    = 3;
`else
    localparam int PMIN       = 2;
    localparam int P_SHORT    = 2;
`endif

    typedef struct {
        bit is_err;
        int cpb;
    } exp_t;

    logic                clk_i   = 1'b0;
    logic                rst_i   = 1'b0;
    logic                start_i = 1'b0;
    logic                rx_i    = 1'b1;
    logic                busy_o;
    logic                valid_o;
    logic                err_o;
    logic [CPBBITSZ-1:0] cpb_o;

    int   total      = 0;
    int   bad        = 0;
    int   n_pulses   = 0;
    int   cpb_ref    = 0;
    int   cpb_seen   = 0;
    bit   prev_pulse = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   wave[$];

    uart_autobaud #(
        .CPBBITSZ  (CPBBITSZ),
        .MINCPB    (MINCPB),
        .SYNCSTAGES(SYNCSTAGES),
        .FILTCYCLES(FILTCYCLES)
    ) dut (
        .rst_i  (rst_i),
        .clk_i  (clk_i),
        .start_i(start_i),
        .rx_i   (rx_i),
        .busy_o (busy_o),
        .valid_o(valid_o),
        .err_o  (err_o),
        .cpb_o  (cpb_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: consume one expectation per output pulse, and watch cpb_o
    // for any change outside a valid_o pulse.
    always @(negedge clk_i) begin
        if (rst_i) begin
            cpb_seen   = 0;
            prev_pulse = 1'b0;
        end else if (valid_o || err_o) begin
            n_pulses++;
            check("pulse_exclusive", valid_o & err_o, 0);
            check("pulse_width", prev_pulse, 0);
            prev_pulse = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_is_err", err_o, mon_e.is_err);
                check("cpb_value", cpb_o, mon_e.cpb);
                cpb_seen = mon_e.cpb;
            end
        end else begin
            prev_pulse = 1'b0;
            check("cpb_stable", cpb_o, cpb_seen);
        end
    end

    task automatic add_idle(input int n);
        repeat (n) wave.push_back(1'b1);
    endtask

    // One 8N1 frame, LSB first; optional +/-1 clock jitter per bit.
    task automatic add_frame(input logic [7:0] ch, input int p, input bit jit);
        bit lvl;
        int len;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      lvl = 1'b0;
            else if (b == 9) lvl = 1'b1;
            else             lvl = ch[b-1];
            len = p;
            if (jit) len = p + int'($urandom_range(2)) - 1;
            repeat (len) wave.push_back(lvl);
        end
    endtask

    task automatic build_55(input int p);
        wave.delete();
        add_idle(4);
        add_frame(8'h55, p, 1'b0);
        add_idle(4);
    endtask

    // Reference model: span between 1st and 5th falling edge of the line.
    // Returns the span, -1 when the measurement must saturate, or -2 when the
    // fifth edge lands exactly on the saturation cycle (avoided by stimulus).
    function automatic int model_span();
        bit lv[$];
        bit prev;
        int falls[$];
        int d;
        lv = wave;
`ifdef UART_AUTOBAUD_GLITCHFILT_EN
        begin
            bit cur;
            int i;
            int j;
            cur = 1'b1;
            i   = 0;
            while (i < lv.size()) begin
                j = i;
                while (j < lv.size() && lv[j] == lv[i]) j++;
                if (j - i >= FILTCYCLES) cur = lv[i];
                for (int k = i; k < j; k++) lv[k] = cur;
                i = j;
            end
        end
`endif
        prev = 1'b1;
        foreach (lv[k]) begin
            if (prev && !lv[k]) falls.push_back(k);
            prev = lv[k];
        end
        if (falls.size() >= 5) begin
            d = falls[4] - falls[0];
            if (d <= SAT) return d;
            if (d == SAT + 1) return -2;
        end
        return -1;
    endfunction

    task automatic pulse_start();
        @(posedge clk_i); #1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // Drive the first 'limit' samples of the waveform, or all of it (then idle).
    task automatic drive_wave(input int limit);
        int n;
        n = (limit < 0) ? wave.size() : limit;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i); #1;
            rx_i = wave[k];
        end
        if (limit < 0) begin
            @(posedge clk_i); #1;
            rx_i = 1'b1;
        end
    endtask

    task automatic run_measure(input string name);
        int   sp;
        int   target;
        int   n;
        exp_t e;
        sp = model_span();
        if (sp >= 8 * MINCPB) begin
            cpb_ref  = ((sp + 4) >> 3) & ((1 << CPBBITSZ) - 1);
            e.is_err = 1'b0;
        end else begin
            e.is_err = 1'b1;
        end
        e.cpb = cpb_ref;
        exp_q.push_back(e);
        target = n_pulses + 1;
        pulse_start();
        check({name, "_busy"}, busy_o, 1);
        drive_wave(-1);
        n = 0;
        while (n_pulses < target && n < 4000) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({name, "_done"}, n_pulses >= target, 1);
        if (n_pulses < target) exp_q.delete();
        check({name, "_idle"}, busy_o, 0);
    endtask

    initial begin
        #2 rst_i = 1'b1;
        #1;
        check("reset_busy", busy_o, 0);
        check("reset_valid", valid_o, 0);
        check("reset_err", err_o, 0);
        check("reset_cpb", cpb_o, 0);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk_i);

        build_55(16);
        run_measure("p16");
        build_55(13);
        run_measure("p13");
        build_55(P_SHORT);
        run_measure("short_span");
        build_55(100);
        run_measure("p100");

        // Start edge followed by a line stuck low: counter must saturate.
        wave.delete();
        add_idle(4);
        repeat (3000) wave.push_back(1'b0);
        add_idle(4);
        run_measure("saturate");

        // One-cycle low glitch in the middle of b0.
        build_55(16);
        wave[4 + 16 + 8] = 1'b0;
        run_measure("glitch");
`ifdef UART_AUTOBAUD_GLITCHFILT_EN
        check("glitch_filtered_cpb", cpb_o, 16);
`else
        check("glitch_not_16", cpb_o != 16, 1);
`endif

        // Asynchronous reset in the middle of a measurement.
        build_55(16);
        pulse_start();
        drive_wave(60);
        check("mid_busy", busy_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_cpb", cpb_o, 0);
        cpb_ref = 0;
        rx_i    = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        build_55(16);
        run_measure("after_reset");

        // Re-arm in the middle of a measurement: no pulse for the dropped one.
        build_55(16);
        pulse_start();
        drive_wave(60);
        build_55(13);
        run_measure("restart");

        // Randomized: 0x55 frames or streams of random characters, with jitter.
        for (int it = 0; it < 16; it++) begin
            int sp;
            int p;
            int mode;
            bit jit;
            do begin
                wave.delete();
                add_idle(4 + int'($urandom_range(8)));
                mode = int'($urandom_range(2));
                if (mode != 0) begin
                    p   = int'($urandom_range(120, PMIN));
                    jit = (p >= 8) && ($urandom_range(1) == 1);
                    add_frame(8'h55, p, jit);
                end else begin
                    p   = int'($urandom_range(30, PMIN));
                    jit = (p >= 8) && ($urandom_range(1) == 1);
                    for (int f = 0; f < 5; f++) begin
                        add_frame(8'($urandom), p, jit);
                        add_idle(int'($urandom_range(p)));
                    end
                end
                add_idle(4);
                sp = model_span();
            end while (sp == -2);
            run_measure($sformatf("rnd%0d", it));
        end

        repeat (10) @(posedge clk_i);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
